// File: rtl/cbus_write_buffer_pkg.sv
// rtl/cbus_write_buffer_pkg.sv - bus types and write-buffer entry/state types
package cbus_write_buffer_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Burst length is encoded as beats-1, matching AXI LEN
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  // Only the fields a single-beat store needs are kept per entry
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strobe;
    msize_t      size;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_DRAIN = 2'd1,
    WB_FWD   = 2'd2
  } wb_state_t;

endpackage

// File: rtl/cbus_write_buffer_fifo.sv
// rtl/cbus_write_buffer_fifo.sv - circular FIFO of posted write entries
module wb_fifo
  import cbus_write_buffer_pkg::*;
#(
  parameter  int DEPTH   = 4,
  localparam int PTR_BIT = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  wb_entry_t          din,
  output wb_entry_t          dout,
  output logic               full,
  output logic               empty,
  output logic [PTR_BIT:0]   count
);

  localparam logic [PTR_BIT:0] PTR_ONE   = {{PTR_BIT{1'b0}}, 1'b1};
  localparam logic [PTR_BIT:0] DEPTH_CNT = (PTR_BIT + 1)'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_BIT:0] head_q, head_d;
  logic [PTR_BIT:0] tail_q, tail_d;
  logic             do_push, do_pop;

  // Extra pointer MSB separates full from empty once the pointers wrap
  assign count   = tail_q - head_q;
  assign full    = (count == DEPTH_CNT);
  assign empty   = (head_q == tail_q);
  assign dout    = mem_q[head_q[PTR_BIT-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Advance pointers and write the tail slot on an accepted push
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    mem_d  = mem_q;
    if (do_pop) begin
      head_d = head_q + PTR_ONE;
    end
    if (do_push) begin
      mem_d[tail_q[PTR_BIT-1:0]] = din;
      tail_d = tail_q + PTR_ONE;
    end
  end

  // Pointers reset; slot contents need no reset since only valid slots are read
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cbus_write_buffer.sv
// rtl/cbus_write_buffer.sv - posted-write buffer in front of the CBus arbiter slot
module cbus_write_buffer
  import cbus_write_buffer_pkg::*;
#(
  parameter  int DEPTH   = 4,
  localparam int PTR_BIT = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireq,
  output cbus_resp_t       iresp,
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             empty,
  output logic [PTR_BIT:0] count
);

  localparam logic [PTR_BIT:0] CNT_ONE = {{PTR_BIT{1'b0}}, 1'b1};

  wb_state_t state_q, state_d;
  wb_entry_t push_entry, head_entry;
  logic      post_kind, post, pop, resp_done;
  logic      fifo_full, fifo_empty;

  // A full FIFO blocks posting on the registered count, so a pop only frees
  // the slot for the next cycle (no same-cycle bypass)
  assign post_kind  = ireq.valid && ireq.is_write && (ireq.len == MLEN1);
  assign post       = post_kind && !fifo_full && (state_q != WB_FWD) && !reset;
  assign resp_done  = oresp.ready && oresp.last;
  assign pop        = (state_q == WB_DRAIN) && resp_done;
  assign empty      = fifo_empty && (state_q == WB_IDLE);
  assign push_entry = '{addr: ireq.addr, data: ireq.data, strobe: ireq.strobe, size: ireq.size};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (post),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // State register; reset drops any in-flight drain or forward
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Non-postable requests only leave IDLE once every buffered write has drained
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_IDLE: begin
        if (count != '0) begin
          state_d = WB_DRAIN;
        end else if (ireq.valid && !post_kind) begin
          state_d = WB_FWD;
        end
      end
      WB_DRAIN: begin
        if (pop && (count == CNT_ONE) && !post) begin
          state_d = WB_IDLE;
        end
      end
      WB_FWD: begin
        if (resp_done) begin
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // Drive the arbiter from the FIFO head or pass through; ack posts locally
  always_comb begin
    oreq  = '0;
    iresp = '0;
    unique case (state_q)
      WB_DRAIN: begin
        oreq.valid    = 1'b1;
        oreq.is_write = 1'b1;
        oreq.len      = MLEN1;
        oreq.burst    = AXI_BURST_FIXED;
        oreq.addr     = head_entry.addr;
        oreq.data     = head_entry.data;
        oreq.strobe   = head_entry.strobe;
        oreq.size     = head_entry.size;
      end
      WB_FWD: begin
        oreq  = ireq;
        iresp = oresp;
      end
      default: ;
    endcase
    if (post) begin
      iresp.ready = 1'b1;
      iresp.last  = 1'b1;
      iresp.data  = '0;
    end
  end

endmodule

// File: tb/tb_cbus_write_buffer.sv
// tb/tb_cbus_write_buffer.sv - self-checking bench for cbus_write_buffer
module tb_cbus_write_buffer;
  import cbus_write_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  cbus_req_t  ireq  = '0;
  cbus_req_t  oreq;
  cbus_resp_t iresp;
  cbus_resp_t oresp = '0;
  logic       empty;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  cbus_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .oreq  (oreq),
    .oresp (oresp),
    .empty (empty),
    .count (count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: queue of posted stores ----------------
  wb_entry_t mq[$];
  bit m_drain = 1'b0;
  bit m_fwd   = 1'b0;

  function automatic bit is_post_kind(cbus_req_t r);
    return r.valid && r.is_write && (r.len == MLEN1);
  endfunction

  function automatic bit model_post();
    return is_post_kind(ireq) && (mq.size() < DEPTH) && !m_fwd && !reset;
  endfunction

  initial forever begin
    bit p, popped, done;
    int old_sz;
    wb_entry_t e;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_drain = 1'b0;
      m_fwd   = 1'b0;
    end else begin
      p      = model_post();
      old_sz = mq.size();
      popped = m_drain && oresp.ready && oresp.last;
      done   = m_fwd && oresp.ready && oresp.last;
      if (popped) void'(mq.pop_front());
      if (p) begin
        e.addr = ireq.addr; e.data = ireq.data; e.strobe = ireq.strobe; e.size = ireq.size;
        mq.push_back(e);
      end
      if (m_drain) begin
        if (popped && mq.size() == 0) m_drain = 1'b0;
      end else if (m_fwd) begin
        if (done) m_fwd = 1'b0;
      end else if (old_sz > 0) begin
        m_drain = 1'b1;
      end else if (ireq.valid && !is_post_kind(ireq)) begin
        m_fwd = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare + drain log ----------------
  logic [31:0] dlog_a[$];
  logic [31:0] dlog_d[$];
  int drain_cyc = -1;
  int first_rd  = -1;

  initial forever begin
    cbus_req_t  eo;
    cbus_resp_t er;
    @(negedge clk);
    if (chk_en) begin
      eo = '0;
      er = '0;
      if (m_drain && mq.size() > 0) begin
        eo.valid = 1'b1; eo.is_write = 1'b1; eo.len = MLEN1; eo.burst = AXI_BURST_FIXED;
        eo.addr = mq[0].addr; eo.data = mq[0].data; eo.strobe = mq[0].strobe; eo.size = mq[0].size;
      end else if (m_fwd) begin
        eo = ireq;
        er = oresp;
      end
      if (model_post()) begin
        er.ready = 1'b1; er.last = 1'b1; er.data = '0;
      end
      check("oreq", oreq, eo);
      check("iresp", iresp, er);
      check("count", count, mq.size());
      check("empty", empty, (mq.size() == 0) && !m_drain && !m_fwd);
      if (oreq.valid && oreq.is_write && oreq.len == MLEN1 && oresp.ready && oresp.last) begin
        dlog_a.push_back(oreq.addr);
        dlog_d.push_back(oreq.data);
        drain_cyc = cyc;
      end
      if (oreq.valid && !oreq.is_write && first_rd < 0) first_rd = cyc;
    end
  end

  // ---------------- memory responder ----------------
  bit hold = 1'b0;
  int lat  = 0;
  int wcnt = 0;
  int beat = 0;

  function automatic logic [31:0] rdata(logic [31:0] a, int b);
    logic [3:0] b4;
    b4 = b[3:0];
    return (a == 32'hbfaf_8000) ? 32'h1234_5678 : {a[15:0], 12'h000, b4};
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      wcnt = 0; beat = 0;
    end else if (oresp.ready) begin
      if (oresp.last) begin beat = 0; wcnt = 0; end
      else beat++;
    end
    #3;
    oresp = '0;
    if (oreq.valid && !hold && !reset) begin
      if (wcnt < lat) wcnt++;
      else begin
        oresp.ready = 1'b1;
        oresp.last  = (beat == int'(oreq.len));
        oresp.data  = oreq.is_write ? 32'h0 : rdata(oreq.addr, beat);
      end
    end
  end

  // ---------------- upstream driver ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic wr, input mlen_t len,
                      output logic [31:0] rd, output int ack_cyc, output int beats);
    int t;
    bit done;
    ireq = '0;
    ireq.valid = 1'b1; ireq.is_write = wr; ireq.addr = a; ireq.data = d;
    ireq.strobe = 4'hf; ireq.size = MSIZE4; ireq.len = len;
    ireq.burst = (len == MLEN1) ? AXI_BURST_FIXED : AXI_BURST_INCR;
    rd = '0; ack_cyc = -1; beats = 0; t = 0; done = 1'b0;
    while (!done && t < 200) begin
      @(negedge clk);
      if (iresp.ready) begin beats++; rd = iresp.data; end
      if (iresp.ready && iresp.last) begin ack_cyc = cyc; done = 1'b1; end
      t++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: addr %0h got no ack, required ack within 200 cycles", a);
    end
    @(posedge clk); #1;
    ireq = '0;
  endtask

  task automatic wait_empty(input string nm);
    int t;
    t = 0;
    while (t < 200) begin
      @(negedge clk);
      if (empty) t = 1000;
      else t++;
    end
    check(nm, empty, 1'b1);
    @(posedge clk); #1;
  endtask

  logic [31:0] ea[$];
  logic [31:0] ed[$];

  task automatic chk_drained(input string nm);
    check({nm, "_n"}, dlog_a.size(), ea.size());
    for (int i = 0; i < ea.size() && i < dlog_a.size(); i++) begin
      check({nm, "_addr"}, dlog_a[i], ea[i]);
      check({nm, "_data"}, dlog_d[i], ed[i]);
    end
    dlog_a.delete(); dlog_d.delete(); ea.delete(); ed.delete();
  endtask

  logic [31:0] rd;
  int b, ackc, t_start, pcyc;
  int ack[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    check("rst_count", count, 3'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_oreq", oreq, 79'd0);
    check("rst_iresp", iresp, 34'd0);
    @(posedge clk); #1;

    // 1: single posted write
    t_start = cyc;
    send(32'hbfaf_f000, 32'h0000_00ff, 1'b1, MLEN1, rd, ackc, b);
    check("t1_ack_cycle", ackc, t_start);
    @(negedge clk);
    check("t1_count1", count, 3'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_oreq_valid", oreq.valid, 1'b1);
    check("t1_oreq_addr", oreq.addr, 32'hbfaf_f000);
    check("t1_oreq_data", oreq.data, 32'h0000_00ff);
    check("t1_oreq_strobe", oreq.strobe, 4'hf);
    @(posedge clk); #1;
    wait_empty("t1_empty");
    check("t1_count0", count, 3'd0);
    ea.push_back(32'hbfaf_f000); ed.push_back(32'h0000_00ff);
    chk_drained("t1");

    // 2: five writes into a stalled memory
    hold = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) send(32'(4 * i), 32'ha5a5_0000 + 32'(i), 1'b1, MLEN1, rd, ack[i], b);
      end
      begin
        repeat (7) @(posedge clk);
        #1; hold = 1'b0; pcyc = cyc;
        @(posedge clk); #1; hold = 1'b1;
      end
    join
    for (int i = 1; i < 4; i++) check("t2_ack_consec", ack[i] - ack[0], i);
    check("t2_ack5_after_pop", ack[4], pcyc + 1);
    hold = 1'b0;
    wait_empty("t2_empty");
    for (int i = 0; i < 5; i++) begin ea.push_back(32'(4 * i)); ed.push_back(32'ha5a5_0000 + 32'(i)); end
    chk_drained("t2");

    // 3: write then read of the same address
    first_rd = -1;
    send(32'hbfaf_8000, 32'hcafe_f00d, 1'b1, MLEN1, rd, ackc, b);
    send(32'hbfaf_8000, 32'h0, 1'b0, MLEN1, rd, ackc, b);
    check("t3_rdata", rd, 32'h1234_5678);
    check("t3_beats", b, 1);
    check("t3_order", first_rd > drain_cyc, 1'b1);
    ea.push_back(32'hbfaf_8000); ed.push_back(32'hcafe_f00d);
    chk_drained("t3");

    // 4: burst read behind two queued writes
    hold = 1'b1;
    first_rd = -1;
    send(32'h200, 32'h1, 1'b1, MLEN1, rd, ackc, b);
    send(32'h204, 32'h2, 1'b1, MLEN1, rd, ackc, b);
    fork
      send(32'h300, 32'h0, 1'b0, MLEN4, rd, ackc, b);
      begin
        repeat (4) @(posedge clk);
        #1; hold = 1'b0;
      end
    join
    check("t4_beats", b, 4);
    check("t4_lastdata", rd, 32'h0300_0003);
    check("t4_order", first_rd > drain_cyc, 1'b1);
    @(negedge clk);
    check("t4_idle_empty", empty, 1'b1);
    @(posedge clk); #1;
    ea.push_back(32'h200); ed.push_back(32'h1);
    ea.push_back(32'h204); ed.push_back(32'h2);
    chk_drained("t4");

    // 5: ten writes with one-cycle memory latency, pointers wrap
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] dv;
      dv = 32'h1111_1111 * 32'(i + 1);
      send(32'h400 + 32'(4 * i), dv, 1'b1, MLEN1, rd, ackc, b);
      ea.push_back(32'h400 + 32'(4 * i)); ed.push_back(dv);
    end
    wait_empty("t5_empty");
    chk_drained("t5");
    lat = 0;

    // 6: reset in the middle of a drain
    hold = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h500 + 32'(4 * i), 32'h55 + 32'(i), 1'b1, MLEN1, rd, ackc, b);
    @(negedge clk);
    check("t6_count3", count, 3'd3);
    check("t6_draining", oreq.valid, 1'b1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("t6_oreq_valid", oreq.valid, 1'b0);
    check("t6_count0", count, 3'd0);
    check("t6_empty", empty, 1'b1);
    @(posedge clk); #1;
    hold = 1'b0;
    t_start = cyc;
    send(32'h600, 32'h0060_0600, 1'b1, MLEN1, rd, ackc, b);
    check("t6_ack_cycle", ackc, t_start);
    wait_empty("t6_empty_after");
    ea.push_back(32'h600); ed.push_back(32'h0060_0600);
    chk_drained("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
